// File: rtl/if_pkg.sv
// Shared fetch/decode types and constants.
// Imported by the instruction queue and its storage.
package if_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_bus_t;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;
  localparam logic [31:0] INST_NOP = 32'h0340_0000;

endpackage

// File: rtl/inst_queue_ram.sv
// Queue storage: one write port, one async read port.
// Not reset; validity is tracked by the pointers.
module inst_queue_ram
  import if_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with wrap-bit pointers.
// INST_QUEUE_BYPASS_EN enables a zero-latency empty-queue bypass.
module inst_queue
  import if_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rdata;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0])
               & (rd_ptr[AW] != wr_ptr[AW]);

  assign in_ready = ~full;
  assign count    = wr_ptr - rd_ptr;
  assign pop      = ~empty & out_ready & ~flush;

`ifdef INST_QUEUE_BYPASS_EN
  logic byp;

  // An empty queue forwards the fetch word straight to decode
  assign byp       = empty & in_valid & ~flush;
  assign out_valid = ~empty | byp;
  assign out_data  = ~empty ? rdata
                   : (byp ? in_data : '0);
  assign push      = in_valid & ~full & ~flush
                   & ~(byp & out_ready);
`else
  assign out_valid = ~empty;
  assign out_data  = ~empty ? rdata : '0;
  assign push      = in_valid & ~full & ~flush;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  inst_queue_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule
